// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared types and default widths for the count wrap monitor
// Purpose: event type encoding, the default FIFO entry layout and width defaults
// used by count_wrap_monitor and evt_fifo. No ports.
package count_mon_pkg;

    localparam int CNT_W_DEF   = 3;
    localparam int STAMP_W_DEF = 16;
    localparam int DEPTH_DEF   = 4;
    localparam int DROP_W_DEF  = 8;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_OVF  = 2'd1,
        EVT_UNF  = 2'd2,
        EVT_ERR  = 2'd3
    } evt_type_e;

    typedef struct packed {
        evt_type_e                typ;
        logic [STAMP_W_DEF-1:0]   stamp;
    } evt_entry_t;

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - first-word-fall-through FIFO for monitor event entries
// Purpose: small FWFT queue; the head entry is visible whenever empty=0.
// Ports:
//   clk, rst      clock and synchronous active-high reset (empties the queue)
//   push          write push_data this cycle (ignored when full unless popping)
//   push_data     entry to store
//   pop           consume the head this cycle (ignored when empty)
//   head          current head entry (undefined content while empty)
//   empty, full   occupancy flags derived from level
//   level         number of stored entries, 0..DEPTH
module evt_fifo
    import count_mon_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = evt_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               pop_ok;
    logic               push_ok;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full queue is still accepted when the head leaves
    // in the same cycle, so occupancy stays at DEPTH.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only observable while level > 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// rtl/count_wrap_monitor.sv - detects wrap and illegal-step events on a counter
// Purpose: samples count every cycle, classifies overflow wrap, underflow wrap
// and illegal steps, timestamps them and queues them in an FWFT FIFO.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   count       monitored counter value
//   evt_valid   head event present
//   evt_ready   consumer takes the head this cycle
//   evt_type    head type (01 OVF, 10 UNF, 11 ERR; 00 when empty)
//   evt_stamp   cycle count at detection (0 when empty)
//   evt_level   FIFO occupancy
//   drop_cnt    saturating count of events lost while the FIFO was full
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int  CNT_W   = CNT_W_DEF,
    parameter int  STAMP_W = STAMP_W_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  DROP_W  = DROP_W_DEF,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   count,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_type,
    output logic [STAMP_W-1:0] evt_stamp,
    output logic [LVL_W-1:0]   evt_level,
    output logic [DROP_W-1:0]  drop_cnt
);

    typedef struct packed {
        evt_type_e            typ;
        logic [STAMP_W-1:0]   stamp;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    logic [STAMP_W-1:0] cycle_q, cycle_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]   prev_count_q, prev_count_d;
    logic               prev_valid_q, prev_valid_d;

    logic [CNT_W-1:0]   delta;
    evt_type_e          det_type;
    logic               det;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    entry_t             push_entry;
    entry_t             head;

    assign delta = count - prev_count_q;

    // Wraps are checked before the generic step test because a wrap is
    // itself a legal +/-1 step modulo 2^CNT_W.
    always_comb begin
        det_type = EVT_NONE;
        if (prev_valid_q) begin
            if (prev_count_q == CNT_ONES && count == '0) begin
                det_type = EVT_OVF;
            end else if (prev_count_q == '0 && count == CNT_ONES) begin
                det_type = EVT_UNF;
            end else if (delta != '0 && delta != CNT_W'(1) && delta != CNT_ONES) begin
                det_type = EVT_ERR;
            end
        end
    end

    assign det        = (det_type != EVT_NONE);
    assign pop        = evt_valid && evt_ready;
    assign push_entry = '{typ: det_type, stamp: cycle_q};

    always_comb begin
        cycle_d      = cycle_q + STAMP_W'(1);
        prev_count_d = count;
        prev_valid_d = 1'b1;
        drop_d       = drop_q;
        if (det && fifo_full && !pop && drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q      <= '0;
            drop_q       <= '0;
            prev_count_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            cycle_q      <= cycle_d;
            drop_q       <= drop_d;
            prev_count_q <= prev_count_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    evt_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (det),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (evt_level)
    );

    assign evt_valid = !fifo_empty;
    assign evt_type  = fifo_empty ? 2'b00 : head.typ;
    assign evt_stamp = fifo_empty ? '0 : head.stamp;
    assign drop_cnt  = drop_q;

endmodule
